// File: rtl/double_tap_delay_line_pkg.sv
// Shared constants and FSM encoding for the double-precision tap delay line.
package double_tap_delay_line_pkg;

    localparam int SAMPLE_W = 64;
    localparam logic [63:0] POS_ZERO = 64'h0;

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } dtd_state_e;

endpackage

// File: rtl/double_tap_delay_line_if.sv
// Tap stream handshake bundle: data, lag index, valid/ready and last marker.
interface double_tap_delay_line_if #(
    parameter int DEPTH = 4,
    parameter int W     = 64
);
    logic [W-1:0]             tap_data;
    logic [$clog2(DEPTH)-1:0] tap_idx;
    logic                     tap_valid;
    logic                     tap_ready;
    logic                     tap_last;

    modport master (
        output tap_data, tap_idx, tap_valid, tap_last,
        input  tap_ready
    );

    modport slave (
        input  tap_data, tap_idx, tap_valid, tap_last,
        output tap_ready
    );
endinterface

// File: rtl/double_rise_detect.sv
// Registered 0->1 detector for the converter ready level; history clears on reset.
module double_rise_detect (
    input  logic clk_operation,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic level_q;

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end
endmodule

// File: rtl/double_tap_delay_line.sv
// Circular sample buffer that streams a lag-ordered snapshot of its contents
// after every capture, queuing at most one follow-up stream.
module double_tap_delay_line
    import double_tap_delay_line_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = SAMPLE_W
) (
    input  logic                     clk_operation,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [W-1:0]             double_in,
    input  logic                     sample_ready,
    double_tap_delay_line_if.master  tap,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic                     primed,
    output logic                     overrun
);
    localparam int IDXW = $clog2(DEPTH);

    logic [W-1:0]    mem  [DEPTH];
    logic [W-1:0]    snap [DEPTH];
    logic [IDXW-1:0] wptr;
    dtd_state_e      state;
    logic            pending;
    logic            start_q;
    logic            rise;
    logic            capture;
    logic            handshake;
    logic            end_hs;
    logic            begin_stream;

    double_rise_detect u_rise (
        .clk_operation (clk_operation),
        .rst           (rst),
        .level         (sample_ready),
        .rise          (rise)
    );

    assign capture      = rise & enable;
    assign handshake    = tap.tap_valid & tap.tap_ready;
    assign end_hs       = handshake & tap.tap_last;
    // A queued capture restarts straight from the final handshake, skipping IDLE.
    assign begin_stream = ((state == ST_IDLE) && start_q) ||
                          ((state == ST_STREAM) && end_hs && pending);
    assign primed       = (fill_count == (IDXW + 1)'(DEPTH));

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= W'(POS_ZERO);
            end
            wptr       <= '0;
            fill_count <= '0;
        end else if (capture) begin
            mem[wptr] <= double_in;
            wptr      <= wptr + 1'b1;
            if (!primed) begin
                fill_count <= fill_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                snap[k] <= '0;
            end
            state         <= ST_IDLE;
            pending       <= 1'b0;
            overrun       <= 1'b0;
            start_q       <= 1'b0;
            tap.tap_valid <= 1'b0;
            tap.tap_last  <= 1'b0;
            tap.tap_idx   <= '0;
            tap.tap_data  <= '0;
        end else begin
            start_q <= capture;

            if (begin_stream) begin
                // Snapshot is stored lag-ordered: snap[k] holds the sample k captures back.
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    snap[k] <= mem[wptr - IDXW'(k + 1)];
                end
                state         <= ST_STREAM;
                tap.tap_valid <= 1'b1;
                tap.tap_last  <= 1'b0;
                tap.tap_idx   <= '0;
                tap.tap_data  <= mem[wptr - IDXW'(1)];
            end else if ((state == ST_STREAM) && handshake) begin
                if (tap.tap_last) begin
                    state         <= ST_IDLE;
                    tap.tap_valid <= 1'b0;
                    tap.tap_last  <= 1'b0;
                end else begin
                    tap.tap_idx  <= tap.tap_idx + 1'b1;
                    tap.tap_data <= snap[tap.tap_idx + 1'b1];
                    tap.tap_last <= ((tap.tap_idx + 1'b1) == IDXW'(DEPTH - 1));
                end
            end

            if ((state == ST_STREAM) && end_hs && pending) begin
                pending <= capture;
            end else if ((state == ST_STREAM) && capture && !end_hs) begin
                if (pending) begin
                    overrun <= 1'b1;
                end
                pending <= 1'b1;
            end
        end
    end
endmodule

// File: doc/double_tap_delay_line.md
DOUBLE_TAP_DELAY_LINE -- requirements
Module: double_tap_delay_line

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning number of stored taps (lag span), power of two, 2..16.
REQ-002 The block SHALL have parameter W, default 64, meaning sample width (IEEE-754 double).
REQ-003 The block SHALL have port clk_operation  input  1  the single operating clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port enable  input  1  when low, no new capture and no new stream starts; an in-progress stream completes.
REQ-006 The block SHALL have port double_in  input  W  sample from the 16-bit-to-double converter.
REQ-007 The block SHALL have port sample_ready  input  1  converter ready level; may stay high for many cycles.
REQ-008 The block SHALL have port tap_data  output  W  streamed tap value.
REQ-009 The block SHALL have port tap_idx  output  log2(DEPTH)  lag of current tap (0 = newest).
REQ-010 The block SHALL have ports tap_valid output 1, tap_ready input 1, tap_last output 1  stream handshake; tap_last marks lag DEPTH-1.
REQ-011 The block SHALL have port fill_count  output  log2(DEPTH)+1  samples stored, saturating at DEPTH.
REQ-012 The block SHALL have ports primed output 1 (fill_count==DEPTH) and overrun output 1 (sticky error).

Function
REQ-013 Capture SHALL occur on the cycle after a 0->1 transition of sample_ready while enable=1: double_in written at write pointer, pointer increments modulo DEPTH.
REQ-014 sample_ready held high SHALL cause exactly one capture; a new capture needs sample_ready low for at least one cycle.
REQ-015 Lag k SHALL read the sample written k captures before the newest; slots never written SHALL read as 64'h0 (+0.0).
REQ-016 FSM states SHALL be IDLE and STREAM; IDLE->STREAM one cycle after a capture; STREAM->IDLE on the handshake with tap_last=1.
REQ-017 In STREAM, tap_valid SHALL be 1 and taps SHALL be presented lag 0 to DEPTH-1, advancing only when tap_valid&tap_ready; data/idx held stable while stalled.
REQ-018 Stream content SHALL be a snapshot of the buffer at stream start; captures during STREAM SHALL NOT alter taps of the ongoing stream.
REQ-019 A capture during STREAM SHALL set a pending flag; on stream end the FSM SHALL go directly to STREAM for the new snapshot with no IDLE cycle.
REQ-020 A capture while pending is already set SHALL still write the buffer, keep pending=1 and set overrun=1 until reset.
REQ-021 fill_count SHALL increment per capture until DEPTH, then hold; primed follows combinationally from the register.
REQ-022 Latency: sample_ready rise at edge N -> capture at N+1 -> first tap_valid at N+2 (tap_ready held high thereafter gives one tap per cycle).

Reset
REQ-023 On rst=0 asynchronously: write pointer 0, fill_count 0, all slots 0, FSM IDLE, pending 0, tap_valid 0, tap_last 0, tap_idx 0, tap_data 0, overrun 0, sample_ready edge register 0.
REQ-024 Reset mid-stream SHALL abort the stream immediately; the first capture after release SHALL see sample_ready edge detection from a 0 history.

Structure
REQ-025 A shared package SHALL hold W, the +0.0 constant 64'h0, and the FSM state encoding.
REQ-026 One sub-module SHALL exist: double_rise_detect (sample_ready edge detector with registered history).
REQ-027 Snapshot SHALL be a DEPTH x W register copy loaded at stream start; no other memories.

Verification
REQ-028 After reset, capture 1.0 (64'h3FF0000000000000), tap_ready=1 -> taps lag0=3FF0..., lags1-3=0, tap_last on idx 3, fill_count=1, primed=0.
REQ-029 Capture 1.0,2.0,3.0,4.0,5.0 spaced 20 cycles -> last stream reads 5.0,4.0,3.0,2.0, primed=1, fill_count=4.
REQ-030 sample_ready held high 50 cycles -> exactly one capture, one stream.
REQ-031 tap_ready low 10 cycles at idx 1 while a capture of 9.0 occurs -> idx 1 data unchanged, pending stream starts the cycle after tap_last handshake with lag0=9.0.
REQ-032 Three captures inside one stalled stream -> overrun=1, remains 1 after further idle, cleared only by rst.
REQ-033 Assert rst at idx 2 of a stream -> tap_valid=0 that instant, fill_count=0; next capture streams value then zeros.
